pipe_hazard_ctrl: RTL
=====================

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, maximum MEM_WAIT cycles before the error state; legal range 1..65535.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-004 SHALL have ports id_rs, id_rt  input  5 each  source register fields of the instruction in ID.
REQ-005 SHALL have port id_uses_rt  input  1  high when the ID instruction reads rt as an operand.
REQ-006 SHALL have ports ex_mem_read  input  1 and ex_rd  input  5  load flag and destination of the instruction in EX.
REQ-007 SHALL have ports id_branch_taken, id_jump  input  1 each  control-transfer resolved in ID.
REQ-008 SHALL have ports mem_req, mem_ready  input  1 each  data-memory access in MEM, and its completion.
REQ-009 SHALL have ports pc_load, ifid_load  output  1 each  load enables for the PC and IF/ID registers.
REQ-010 SHALL have ports ifid_flush, idex_flush  output  1 each  synchronous-clear requests for IF/ID and ID/EX.
REQ-011 SHALL have port pipe_hold  output  1  freeze request for ID/EX, EX/MEM and MEM/WB.
REQ-012 SHALL have port err  output  1  sticky memory-timeout flag.
REQ-013 SHALL have ports stall_cnt, flush_cnt  output  16 each  saturating performance counters.

Function
REQ-014 SHALL implement FSM states RUN, MEM_WAIT, ERR; outputs are combinational from state and inputs.
REQ-015 SHALL define load_use = ex_mem_read & (ex_rd != 0) & ((ex_rd == id_rs) | (id_uses_rt & (ex_rd == id_rt))).
REQ-016 SHALL, in RUN with mem_req=1 and mem_ready=0, drive pc_load=0, ifid_load=0, pipe_hold=1, flushes=0 in that same cycle, then enter MEM_WAIT.
REQ-017 SHALL, in RUN with no memory wait and load_use=1, drive pc_load=0, ifid_load=0, idex_flush=1, ifid_flush=0, pipe_hold=0 (one bubble), and remain in RUN.
REQ-018 SHALL, in RUN with no memory wait, load_use=0 and (id_branch_taken | id_jump)=1, drive ifid_flush=1, pc_load=1, ifid_load=1.
REQ-019 SHALL ignore id_branch_taken and id_jump in any cycle where a memory wait or load_use is active (priority: memory wait > load_use > control transfer).
REQ-020 SHALL otherwise drive, in RUN, pc_load=1, ifid_load=1, flushes=0, pipe_hold=0.
REQ-021 SHALL, in MEM_WAIT, hold pc_load=0, ifid_load=0, pipe_hold=1 while mem_ready=0; in the cycle mem_ready=1, drive RUN-equivalent outputs from REQ-017..020 and return to RUN.
REQ-022 SHALL count consecutive MEM_WAIT cycles in a 16-bit wait counter, cleared on entry to MEM_WAIT; when the count reaches TIMEOUT with mem_ready=0, enter ERR.
REQ-023 SHALL, in ERR, drive pc_load=0, ifid_load=0, pipe_hold=1, err=1, and leave ERR only through reset.
REQ-024 SHALL increment stall_cnt on every clock edge where pc_load=0 outside reset, saturating at 16'hFFFF.
REQ-025 SHALL increment flush_cnt on every edge where ifid_flush=1 outside reset, saturating at 16'hFFFF.
REQ-026 SHALL, when mem_ready=1 in the same cycle as mem_req=1 in RUN, apply no stall (zero-wait access).

Reset
REQ-027 SHALL, while rst=0, force state RUN, wait counter 0, stall_cnt=0, flush_cnt=0, err=0, and drive pc_load=0, ifid_load=0, ifid_flush=1, idex_flush=1, pipe_hold=1.
REQ-028 SHALL abandon any MEM_WAIT or ERR immediately on rst assertion; first post-reset cycle is RUN.

Verification
REQ-029 SHALL cover load-use: ex_mem_read=1, ex_rd=5, id_rs=5 for one cycle -> pc_load=0, idex_flush=1 for one cycle, stall_cnt=1.
REQ-030 SHALL cover zero register: ex_mem_read=1, ex_rd=0, id_rs=0 -> no stall, pc_load=1.
REQ-031 SHALL cover branch masked by load-use: load_use=1 and id_branch_taken=1 same cycle -> ifid_flush=0, flush_cnt unchanged; next cycle branch only -> ifid_flush=1, flush_cnt=1.
REQ-032 SHALL cover memory wait: mem_req=1, mem_ready low 3 cycles then high -> pipe_hold=1 for 3 cycles, released in ready cycle, stall_cnt=3.
REQ-033 SHALL cover timeout with TIMEOUT=4: mem_ready held 0 -> err=1 after 4 MEM_WAIT cycles, stays 1 until rst=0, then err=0 and counters 0.
REQ-034 SHALL cover saturation: force 70000 stall cycles -> stall_cnt holds 16'hFFFF.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use bubbles, control-transfer flushes and
// data-memory wait stalls with a timeout error state and saturating counters.
module pipe_hazard_ctrl #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_uses_rt,
  input  logic        ex_mem_read,
  input  logic [4:0]  ex_rd,
  input  logic        id_branch_taken,
  input  logic        id_jump,
  input  logic        mem_req,
  input  logic        mem_ready,
  output logic        pc_load,
  output logic        ifid_load,
  output logic        ifid_flush,
  output logic        idex_flush,
  output logic        pipe_hold,
  output logic        err,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERR      = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] wait_q, wait_d;
  logic [16:0] wait_inc;
  logic        load_use;
  logic        mem_stall;
  logic        hold;

  assign load_use  = ex_mem_read & (ex_rd != 5'd0) &
                     ((ex_rd == id_rs) | (id_uses_rt & (ex_rd == id_rt)));
  assign mem_stall = mem_req & ~mem_ready;
  assign wait_inc  = {1'b0, wait_q} + 17'd1;

  // NOTE: every signal written here gets a default first, so no path can leave
  // one unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    wait_d     = wait_q;
    hold       = 1'b0;
    err        = 1'b0;
    pc_load    = 1'b1;
    ifid_load  = 1'b1;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    pipe_hold  = 1'b0;

    case (state_q)
      RUN: begin
        if (mem_stall) begin
          hold    = 1'b1;
          state_d = MEM_WAIT;
          wait_d  = 16'd0;
        end
      end
      MEM_WAIT: begin
        if (mem_ready) begin
          state_d = RUN;
        end else begin
          hold = 1'b1;
          if (wait_inc >= 17'(TIMEOUT)) state_d = ERR;
          else                          wait_d  = wait_inc[15:0];
        end
      end
      ERR: begin
        hold = 1'b1;
        err  = 1'b1;
      end
      default: begin
        hold    = 1'b1;
        state_d = RUN;
      end
    endcase

    // Priority: memory wait, then load-use bubble, then control transfer.
    if (hold) begin
      pc_load   = 1'b0;
      ifid_load = 1'b0;
      pipe_hold = 1'b1;
    end else if (load_use) begin
      pc_load    = 1'b0;
      ifid_load  = 1'b0;
      idex_flush = 1'b1;
    end else if (id_branch_taken | id_jump) begin
      ifid_flush = 1'b1;
    end

    // While reset is held the pipeline is frozen and both stage registers cleared.
    if (!rst) begin
      state_d    = RUN;
      wait_d     = 16'd0;
      err        = 1'b0;
      pc_load    = 1'b0;
      ifid_load  = 1'b0;
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
      pipe_hold  = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together from pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RUN;
      wait_q  <= 16'd0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= 16'd0;
      flush_cnt <= 16'd0;
    end else begin
      if (!pc_load && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
      if (ifid_flush && flush_cnt != 16'hFFFF) flush_cnt <= flush_cnt + 16'd1;
    end
  end

endmodule
